// File: rtl/mult_div_unit.sv
// Purpose : iterative signed MULT (radix-2 Booth) / DIV (restoring) unit for the HI/LO registers.
// Latency : WIDTH+1 edges from accepted start to hi/lo/done; a DIV by zero or a DIV without the divider completes at edge 0.
// Backpr. : no queueing; start is accepted only while idle and ignored while busy=1.
// Ports   : clk, reset (async, active-high); start, op (0=MULT, 1=DIV), a, b operands;
//           hi/lo results (MULT: product halves, DIV: remainder/quotient), busy, done (1-cycle), div_zero.
// Config  : define MULT_DIV_UNIT_DIV_EN to build the divider datapath and DIV state; when it is
//           undefined, a DIV request only produces a done pulse and leaves hi/lo untouched.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_MULT, ST_DIV} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;

  // Booth accumulator {upper, lower, q-1}. The upper half carries one guard bit so that
  // subtracting a most-negative multiplicand cannot overflow before the arithmetic shift.
  logic [2*WIDTH+1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH:0]     mcand_x;
  logic [WIDTH:0]     upper;
  logic [WIDTH:0]     upper_nxt;
  logic [2*WIDTH+1:0] booth_nxt;

  assign mcand_x = {mcand[WIDTH-1], mcand};
  assign upper   = acc[2*WIDTH+1:WIDTH+1];

  always_comb begin
    upper_nxt = upper;
    case (acc[1:0])
      2'b01:   upper_nxt = upper + mcand_x;
      2'b10:   upper_nxt = upper - mcand_x;
      default: upper_nxt = upper;
    endcase
  end

  // Arithmetic shift right of {upper_nxt, lower, q-1}; the old q-1 falls off the end.
  assign booth_nxt = {upper_nxt[WIDTH], upper_nxt, acc[WIDTH:1]};

`ifdef MULT_DIV_UNIT_DIV_EN
  // Restoring divider on magnitudes. quo starts as |a| and is shifted out MSB-first
  // while quotient bits are shifted in at the bottom.
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_nxt;

  // -2^(WIDTH-1) maps onto itself, which is the correct unsigned magnitude.
  assign a_mag    = a[WIDTH-1] ? -a : a;
  assign b_mag    = b[WIDTH-1] ? -b : b;
  assign rem_sh   = {rem, quo[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, dvsr};
  assign q_bit    = ~rem_diff[WIDTH];
  // Remainder is always below the divisor, so WIDTH bits suffice in both branches.
  assign rem_nxt  = q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
`ifdef MULT_DIV_UNIT_DIV_EN
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            div_zero <= 1'b0;
            cnt      <= '0;
            if (!op) begin
              acc   <= {{(WIDTH+1){1'b0}}, b, 1'b0};
              mcand <= a;
              busy  <= 1'b1;
              state <= ST_MULT;
            end else begin
`ifdef MULT_DIV_UNIT_DIV_EN
              if (b == '0) begin
                // Divide by zero: report immediately, results untouched.
                div_zero <= 1'b1;
                done     <= 1'b1;
              end else begin
                quo   <= a_mag;
                rem   <= '0;
                dvsr  <= b_mag;
                neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                neg_r <= a[WIDTH-1];
                busy  <= 1'b1;
                state <= ST_DIV;
              end
`else
              // No divider built: acknowledge the request and leave hi/lo alone.
              done <= 1'b1;
`endif
            end
          end
        end

        ST_MULT: begin
          if (cnt == CW'(WIDTH)) begin
            hi    <= acc[2*WIDTH:WIDTH+1];
            lo    <= acc[WIDTH:1];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            acc <= booth_nxt;
            cnt <= cnt + 1'b1;
          end
        end

`ifdef MULT_DIV_UNIT_DIV_EN
        ST_DIV: begin
          if (cnt == CW'(WIDTH)) begin
            // Truncating division: quotient sign from sign(a)^sign(b), remainder follows a.
            lo    <= neg_q ? -quo : quo;
            hi    <= neg_r ? -rem : rem;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            rem <= rem_nxt;
            quo <= {quo[WIDTH-2:0], q_bit};
            cnt <= cnt + 1'b1;
          end
        end
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Purpose : directed self-checking bench for mult_div_unit (both divider build options).
// Latency : checks WIDTH+1 edge completion, 1-edge divide-by-zero / no-divider completion.
// Backpr. : exercises start ignored while busy and back-to-back start in the done cycle.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         div_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request for exactly one edge (edge 0), then scramble the operand inputs.
  task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 1'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  // Count edges until done; busy must stay high before it and be low with it.
  task automatic wait_done(input string tag, input int exp_n);
    int n = 0;
    bit busy_ok = 1'b1;
    for (int i = 1; i <= W + 8; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    check({tag, "_latency"}, n, exp_n);
    check({tag, "_busy_held"}, busy_ok, 1);
    check({tag, "_busy_end"}, busy, 0);
  endtask

  task automatic run(input string tag, input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    issue(o, x, y);
    check({tag, "_busy0"}, busy, 1);
    check({tag, "_done0"}, done, 0);
    wait_done(tag, W + 1);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

`ifndef MULT_DIV_UNIT_DIV_EN
  // Without the divider a DIV request only acknowledges at edge 0.
  task automatic div_absent(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic [W-1:0] keep_hi, input logic [W-1:0] keep_lo);
    issue(1'b1, x, y);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_dz"}, div_zero, 0);
    check({tag, "_hi"}, hi, keep_hi);
    check({tag, "_lo"}, lo, keep_lo);
  endtask
`endif

  initial begin
    logic op_r;
    bit   seen;

    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_zero, 0);
    @(negedge clk);
    reset = 1'b0;

    // 7 * -3 = -21
    run("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    @(posedge clk);
    #1;
    check("mul_7_m3_done_clr", done, 0);

    // (-2^31)^2 = 2^62, then back-to-back (start in the done cycle): (2^31-1)^2
    run("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run("mul_max_max", 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001);

`ifdef MULT_DIV_UNIT_DIV_EN
    run("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    issue(1'b1, 32'h0000_1234, 32'd0);
    check("dz_done", done, 1);
    check("dz_flag", div_zero, 1);
    check("dz_busy", busy, 0);
    check("dz_hi_keep", hi, 32'h0000_0000);
    check("dz_lo_keep", lo, 32'h8000_0000);
    @(posedge clk);
    #1;
    check("dz_done_clr", done, 0);
    check("dz_flag_hold", div_zero, 1);
    op_r = 1'b1;
`else
    div_absent("nodiv_10_0", 32'd10, 32'd0, 32'h3FFF_FFFF, 32'h0000_0001);
    div_absent("nodiv_m7_2", 32'hFFFF_FFF9, 32'd2, 32'h3FFF_FFFF, 32'h0000_0001);
    @(posedge clk);
    #1;
    check("nodiv_done_clr", done, 0);
    op_r = 1'b0;
`endif

    // 5 * 6 with a competing start at edge 10 that must be ignored.
    issue(1'b0, 32'd5, 32'd6);
    check("ign_dz_clr", div_zero, 0);
    check("ign_busy0", busy, 1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    a     = 32'd100;
    b     = 32'd100;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ign", W + 1 - 10);
    check("ign_hi", hi, 32'd0);
    check("ign_lo", lo, 32'd30);

    // Reset asserted around edge 20 of an operation: abort, no done.
    issue(op_r, 32'd100, 32'd7);
    repeat (19) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < W + 8; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    check("abort_no_done", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
